// File: rtl/dds_phase_accumulator_if.sv
// Control and status bundle between the frequency selector, the phase accumulator
// and the waveform ROM address port.
interface dds_phase_accumulator_if #(
  parameter int FW_W   = 8,
  parameter int ADDR_W = 8
);
  logic              en;
  logic [FW_W-1:0]   freq_word;
  logic              freq_load;
  logic              phase_clr;
  logic [ADDR_W-1:0] rom_addr;
  logic              addr_valid;
  logic              wrap;
  logic              freq_busy;
  logic [15:0]       period_cnt;

  modport master (
    output en, freq_word, freq_load, phase_clr,
    input  rom_addr, addr_valid, wrap, freq_busy, period_cnt
  );

  modport slave (
    input  en, freq_word, freq_load, phase_clr,
    output rom_addr, addr_valid, wrap, freq_busy, period_cnt
  );
endinterface

// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator: wrapping phase register with glitch-free frequency
// changes (shadow word applied at phase wrap) and a saturating period counter.
module dds_phase_accumulator #(
  parameter int ACC_W  = 16,
  parameter int FW_W   = 8,
  parameter int ADDR_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  dds_phase_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } mode_e;

  mode_e            mode_s;
  logic [ACC_W-1:0] acc_r;
  logic [FW_W-1:0]  active_fw_r;
  logic [FW_W-1:0]  shadow_fw_r;
  logic             pending_r;
  logic             wrap_r;
  logic             addr_valid_r;
  logic [15:0]      period_cnt_r;

  logic [ACC_W-1:0] fw_ext_s;
  logic [ACC_W:0]   sum_s;
  logic             load_now_s;

  logic [ACC_W-1:0] acc_run_s;
  logic             carry_run_s;
  logic [FW_W-1:0]  active_run_s;
  logic [FW_W-1:0]  shadow_run_s;
  logic             pending_run_s;

  logic [ACC_W-1:0] acc_nxt_s;
  logic             carry_s;
  logic [FW_W-1:0]  active_nxt_s;
  logic [FW_W-1:0]  shadow_nxt_s;
  logic             pending_nxt_s;
  logic [15:0]      cnt_nxt_s;

  assign fw_ext_s   = ACC_W'(active_fw_r);
  assign sum_s      = {1'b0, acc_r} + {1'b0, fw_ext_s};
  // A word loaded while parked at phase zero cannot glitch, so it bypasses the shadow.
  assign load_now_s = bus.freq_load && (acc_r == {ACC_W{1'b0}}) && !bus.en;

  // Decode the operating mode from enable and the pending shadow word.
  always_comb begin
    mode_s = ST_IDLE;
    if (!bus.en) begin
      mode_s = ST_IDLE;
    end else if (pending_r) begin
      mode_s = ST_RUN_PEND;
    end else begin
      mode_s = ST_RUN;
    end
  end

  // Accumulate and frequency-word handover, ignoring phase clear.
  always_comb begin
    acc_run_s     = acc_r;
    carry_run_s   = 1'b0;
    active_run_s  = active_fw_r;
    shadow_run_s  = shadow_fw_r;
    pending_run_s = pending_r;
    case (mode_s)
      ST_IDLE: begin
        acc_run_s   = acc_r;
        carry_run_s = 1'b0;
      end
      ST_RUN: begin
        acc_run_s   = sum_s[ACC_W-1:0];
        carry_run_s = sum_s[ACC_W];
      end
      ST_RUN_PEND: begin
        acc_run_s   = sum_s[ACC_W-1:0];
        carry_run_s = sum_s[ACC_W];
        if (sum_s[ACC_W]) begin
          active_run_s  = shadow_fw_r;
          pending_run_s = 1'b0;
        end else begin
          active_run_s  = active_fw_r;
          pending_run_s = 1'b1;
        end
      end
      default: begin
        acc_run_s   = acc_r;
        carry_run_s = 1'b0;
      end
    endcase
    // A load landing on the applying wrap re-arms the shadow for the next wrap.
    if (load_now_s) begin
      active_run_s  = bus.freq_word;
      pending_run_s = 1'b0;
    end else if (bus.freq_load) begin
      shadow_run_s  = bus.freq_word;
      pending_run_s = 1'b1;
    end else begin
      shadow_run_s  = shadow_fw_r;
    end
  end

  // Phase clear overrides the accumulate path.
  always_comb begin
    acc_nxt_s     = acc_run_s;
    carry_s       = carry_run_s;
    active_nxt_s  = active_run_s;
    shadow_nxt_s  = shadow_run_s;
    pending_nxt_s = pending_run_s;
    cnt_nxt_s     = period_cnt_r;
    if (bus.phase_clr) begin
      acc_nxt_s     = {ACC_W{1'b0}};
      carry_s       = 1'b0;
      pending_nxt_s = 1'b0;
      cnt_nxt_s     = 16'h0000;
      if (bus.freq_load) begin
        active_nxt_s = bus.freq_word;
      end else if (pending_r) begin
        active_nxt_s = shadow_fw_r;
      end else begin
        active_nxt_s = active_fw_r;
      end
    end else if (carry_run_s && (period_cnt_r != 16'hFFFF)) begin
      cnt_nxt_s = period_cnt_r + 16'd1;
    end else begin
      cnt_nxt_s = period_cnt_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r        <= {ACC_W{1'b0}};
      active_fw_r  <= {FW_W{1'b0}};
      shadow_fw_r  <= {FW_W{1'b0}};
      pending_r    <= 1'b0;
      wrap_r       <= 1'b0;
      addr_valid_r <= 1'b0;
      period_cnt_r <= 16'h0000;
    end else begin
      acc_r        <= acc_nxt_s;
      active_fw_r  <= active_nxt_s;
      shadow_fw_r  <= shadow_nxt_s;
      pending_r    <= pending_nxt_s;
      wrap_r       <= carry_s;
      addr_valid_r <= bus.en;
      period_cnt_r <= cnt_nxt_s;
    end
  end

  assign bus.rom_addr   = acc_r[ACC_W-1 -: ADDR_W];
  assign bus.addr_valid = addr_valid_r;
  assign bus.wrap       = wrap_r;
  assign bus.freq_busy  = pending_r;
  assign bus.period_cnt = period_cnt_r;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Scoreboard bench for dds_phase_accumulator: an arithmetic phase model predicts
// every cycle's outputs; a monitor compares them as the DUT presents each result.
module tb_dds_phase_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dds_phase_accumulator_if #(.FW_W(8), .ADDR_W(8)) dif ();
  dds_phase_accumulator_if #(.FW_W(8), .ADDR_W(8)) sif ();

  dds_phase_accumulator #(.ACC_W(16), .FW_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .bus(dif.slave));

  dds_phase_accumulator #(.ACC_W(8), .FW_W(8), .ADDR_W(8)) dut_sat (
    .clk(clk), .rst(rst), .bus(sif.slave));

  typedef struct {
    logic [7:0]  addr;
    logic        av;
    logic        wr;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;
  bit sat_done = 1'b0;

  // Reference model: phase as a plain integer in [0, 65536).
  int m_phase  = 0;
  int m_active = 0;
  int m_shadow = 0;
  bit m_pend   = 1'b0;
  int m_cnt    = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit en, input bit fl, input int fw, input bit pc);
    exp_t e;
    int   s;
    int   old_phase;
    bit   carry;
    @(negedge clk);
    dif.en        = en;
    dif.freq_load = fl;
    dif.freq_word = fw[7:0];
    dif.phase_clr = pc;
    carry     = 1'b0;
    old_phase = m_phase;
    if (pc) begin
      m_active = fl ? fw : (m_pend ? m_shadow : m_active);
      m_phase  = 0;
      m_cnt    = 0;
      m_pend   = 1'b0;
    end else begin
      if (en) begin
        s       = m_phase + m_active;
        carry   = (s >= 65536);
        m_phase = s % 65536;
      end
      if (fl && old_phase == 0 && !en) begin
        m_active = fw;
        m_pend   = 1'b0;
      end else begin
        if (carry && m_pend) begin
          m_active = m_shadow;
          m_pend   = 1'b0;
        end
        if (fl) begin
          m_shadow = fw;
          m_pend   = 1'b1;
        end
      end
      if (carry && m_cnt < 65535) m_cnt++;
    end
    e.addr = 8'(m_phase / 256);
    e.av   = en;
    e.wr   = carry;
    e.busy = m_pend;
    e.cnt  = 16'(m_cnt);
    sb_q.push_back(e);
  endtask

  // Monitor: one expected record per clock the driver issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        total++;
        if (dif.rom_addr !== e.addr || dif.addr_valid !== e.av || dif.wrap !== e.wr ||
            dif.freq_busy !== e.busy || dif.period_cnt !== e.cnt) begin
          bad++;
          $display("FAIL sb t=%0t: got addr=%0h av=%0b wrap=%0b busy=%0b cnt=%0d want addr=%0h av=%0b wrap=%0b busy=%0b cnt=%0d",
                   $time, dif.rom_addr, dif.addr_valid, dif.wrap, dif.freq_busy, dif.period_cnt,
                   e.addr, e.av, e.wr, e.busy, e.cnt);
        end
      end
    end
  end

  // Saturation run on a narrow accumulator, in parallel with the main sequence.
  initial begin
    int sacc;
    int scnt;
    sif.en = 1'b0; sif.freq_load = 1'b0; sif.freq_word = 8'd0; sif.phase_clr = 1'b0;
    wait (rst === 1'b1);
    wait (rst === 1'b0);
    @(negedge clk);
    sif.freq_load = 1'b1;
    sif.freq_word = 8'd255;
    @(negedge clk);
    sif.freq_load = 1'b0;
    sif.en = 1'b1;
    sacc = 0;
    scnt = 0;
    for (int i = 0; i < 66000; i++) begin
      @(posedge clk);
      if (sacc + 255 >= 256 && scnt < 65535) scnt++;
      sacc = (sacc + 255) % 256;
      if (i == 999 || i == 65700) begin
        #1;
        chk("sat_progress", 32'(sif.period_cnt), 32'(scnt));
      end
    end
    #1;
    chk("sat_model", 32'(sif.period_cnt), 32'(scnt));
    chk("sat_ffff", 32'(sif.period_cnt), 32'h0000FFFF);
    @(negedge clk);
    sif.en = 1'b0;
    sat_done = 1'b1;
  end

  initial begin
    int first_wrap;
    int wraps;
    int waited;
    logic [7:0] held_addr;
    rst = 1'b1;
    dif.en = 1'b0; dif.freq_load = 1'b0; dif.freq_word = 8'd0; dif.phase_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(dif.rom_addr), 32'd0);
    chk("rst_valid", 32'(dif.addr_valid), 32'd0);
    chk("rst_busy", 32'(dif.freq_busy), 32'd0);
    chk("rst_cnt", 32'(dif.period_cnt), 32'd0);
    rst = 1'b0;

    // Reset then run at 128: immediate load at phase zero, wrap after 512 steps.
    drive(1'b0, 1'b1, 128, 1'b0);
    settle();
    chk("immediate_load_busy", 32'(dif.freq_busy), 32'd0);
    first_wrap = 0;
    for (int i = 1; i <= 515; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0);
      settle();
      if (dif.wrap === 1'b1 && first_wrap == 0) first_wrap = i;
    end
    chk("first_wrap_cycle", 32'(first_wrap), 32'd512);
    chk("period_after_first", 32'(dif.period_cnt), 32'd1);

    // Load exactly on a carry cycle: old word runs one more full period.
    for (int i = 0; i < 1000; i++) begin
      if (m_phase + m_active >= 65536) begin
        drive(1'b1, 1'b1, 64, 1'b0);
        break;
      end
      drive(1'b1, 1'b0, 0, 1'b0);
    end
    wraps = 0;
    first_wrap = 0;
    for (int i = 1; i <= 522; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0);
      settle();
      if (dif.wrap === 1'b1) begin
        wraps++;
        if (first_wrap == 0) first_wrap = i;
      end
    end
    chk("coinc_wrap_at", 32'(first_wrap), 32'd512);
    chk("coinc_wraps", 32'(wraps), 32'd1);
    chk("coinc_busy", 32'(dif.freq_busy), 32'd0);
    chk("coinc_addr", 32'(dif.rom_addr), 32'd2);

    // Glitch-free change from 128 to 1 starting at phase 0x4000.
    drive(1'b1, 1'b1, 128, 1'b1);
    repeat (128) drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("glitch_start_addr", 32'(dif.rom_addr), 32'h40);
    drive(1'b1, 1'b1, 1, 1'b0);
    settle();
    chk("glitch_busy", 32'(dif.freq_busy), 32'd1);
    repeat (382) drive(1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("glitch_wrap", 32'(dif.wrap), 32'd1);
    chk("glitch_busy_fall", 32'(dif.freq_busy), 32'd0);
    repeat (255) drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("fw1_addr_255", 32'(dif.rom_addr), 32'd0);
    drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("fw1_addr_256", 32'(dif.rom_addr), 32'd1);

    // phase_clr with freq_load: word 4 active at once, address every 64 cycles.
    drive(1'b1, 1'b1, 4, 1'b1);
    settle();
    chk("clr_addr", 32'(dif.rom_addr), 32'd0);
    chk("clr_cnt", 32'(dif.period_cnt), 32'd0);
    chk("clr_busy", 32'(dif.freq_busy), 32'd0);
    repeat (63) drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("fw4_addr_63", 32'(dif.rom_addr), 32'd0);
    drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("fw4_addr_64", 32'(dif.rom_addr), 32'd1);

    // Enable gap freezes the phase.
    held_addr = dif.rom_addr;
    repeat (10) drive(1'b0, 1'b0, 0, 1'b0);
    settle();
    chk("gap_addr", 32'(dif.rom_addr), 32'(held_addr));
    chk("gap_valid", 32'(dif.addr_valid), 32'd0);
    repeat (64) drive(1'b1, 1'b0, 0, 1'b0);
    settle();
    chk("gap_resume", 32'(dif.rom_addr), 32'(held_addr) + 32'd1);

    // Zero word: phase static, no wraps.
    drive(1'b1, 1'b1, 0, 1'b1);
    wraps = 0;
    for (int i = 0; i < 1000; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0);
      settle();
      if (dif.wrap === 1'b1) wraps++;
    end
    chk("zero_wraps", 32'(wraps), 32'd0);
    chk("zero_addr", 32'(dif.rom_addr), 32'd0);
    chk("zero_valid", 32'(dif.addr_valid), 32'd1);

    // Randomized traffic, mostly large power-of-two words.
    drive(1'b1, 1'b1, 128, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      int fw;
      fw = ($urandom_range(0, 9) == 0) ? 0 : (1 << $urandom_range(3, 7));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 99) < 3, fw,
            $urandom_range(0, 299) == 0);
    end
    drive(1'b0, 1'b0, 0, 1'b0);

    waited = 0;
    while (!sat_done && waited < 80000) begin
      @(negedge clk);
      waited++;
    end
    chk("sat_finished", 32'(sat_done), 32'd1);

    // Asynchronous reset mid-run clears everything immediately.
    drive(1'b1, 1'b1, 128, 1'b1);
    repeat (20) drive(1'b1, 1'b0, 0, 1'b0);
    drive(1'b1, 1'b1, 4, 1'b0);
    settle();
    settle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("pre_rst_busy", 32'(dif.freq_busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_rst_addr", 32'(dif.rom_addr), 32'd0);
    chk("async_rst_valid", 32'(dif.addr_valid), 32'd0);
    chk("async_rst_busy", 32'(dif.freq_busy), 32'd0);
    chk("async_rst_cnt", 32'(dif.period_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
